// File: rtl/touch_pkg.sv
// touch_pkg: shared types and constants for the touchscreen UART receiver
// Exports: bit_state_e (byte deserializer FSM), pkt_state_e (packet FSM),
//   SYNC_BIT, PEN_BIT, COORD_W.
// Optional feature macro: TOUCH_UART_RX_PARITY_EN adds the BS_PARITY state.
package touch_pkg;
  localparam int SYNC_BIT = 7;
  localparam int PEN_BIT  = 0;
  localparam int COORD_W  = 12;
  typedef enum logic [2:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
`ifdef TOUCH_UART_RX_PARITY_EN
    BS_PARITY,
`endif
    BS_STOP,
    BS_WAIT_IDLE
  } bit_state_e;
  typedef enum logic [2:0] {
    PS_SYNC,
    PS_B1,
    PS_B2,
    PS_B3,
    PS_B4
  } pkt_state_e;
endpackage

// File: rtl/touch_uart_rx_byte.sv
// uart_rx_byte: oversampling UART byte deserializer (8N1, or 8E1 with TOUCH_UART_RX_PARITY_EN)
// Ports: clk, reset_n (async active-low), rxd (async serial in, idle high),
//   byte_valid (1-cycle strobe in the stop-bit sample cycle), byte_data (valid with strobe),
//   frame_err (1-cycle strobe on bad stop or bad parity).
module uart_rx_byte
  import touch_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  logic        s1_q, s2_q, prev_q;
  bit_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= BS_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      s1_q    <= rxd;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    idx_d      = idx_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      BS_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) state_d = BS_START;
      end
      // Mid-start-bit check rejects short glitches as false starts.
      BS_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = s2_q ? BS_IDLE : BS_DATA;
      end
      BS_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        sh_d  = {s2_q, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
`ifdef TOUCH_UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = BS_PARITY;
`else
        if (idx_q == 3'd7) state_d = BS_STOP;
`endif
      end
`ifdef TOUCH_UART_RX_PARITY_EN
      BS_PARITY: if (cnt_q == LAST) begin
        cnt_d     = '0;
        frame_err = s2_q != ^sh_q;
        state_d   = frame_err ? BS_WAIT_IDLE : BS_STOP;
      end
`endif
      BS_STOP: if (cnt_q == LAST) begin
        cnt_d      = '0;
        byte_valid = s2_q;
        frame_err  = !s2_q;
        state_d    = s2_q ? BS_IDLE : BS_WAIT_IDLE;
      end
      BS_WAIT_IDLE: begin
        cnt_d = '0;
        if (s2_q) state_d = BS_IDLE;
      end
      default: state_d = BS_IDLE;
    endcase
  end
  assign byte_data = sh_q;
endmodule

// File: rtl/touch_uart_rx.sv
// touch_uart_rx: touchscreen UART packet decoder with valid/ready output handshake
// Ports: clk, reset_n (async active-low), rxd (serial in), touch_ready (consumer accept),
//   touch_valid/touch_x/touch_y/touch_pen (held sample), frame_err, pkt_err, overrun (1-cycle pulses).
// Packet: B1 (bit7=1, pen in bit0), then B2..B5 with bit7=0 carrying x lo/hi, y lo/hi.
// Optional feature macro: TOUCH_UART_RX_PARITY_EN (even parity per byte).
module touch_uart_rx
  import touch_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rxd,
  output logic         touch_valid,
  input  logic         touch_ready,
  output logic [11:0]  touch_x,
  output logic [11:0]  touch_y,
  output logic         touch_pen,
  output logic         frame_err,
  output logic         pkt_err,
  output logic         overrun
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  logic               byte_valid, byte_ferr;
  logic [7:0]         byte_data;
  pkt_state_e         pstate_q, pstate_d;
  logic [6:0]         b1_q, b1_d, b3_q, b3_d;
  logic [4:0]         b2_q, b2_d;
  logic               pen_q, pen_d;
  logic               valid_q, valid_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               open_q, open_d;
  logic               ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
  logic               done;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (byte_ferr)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pstate_q <= PS_SYNC;
      b1_q     <= '0;
      b2_q     <= '0;
      b3_q     <= '0;
      pen_q    <= 1'b0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      open_q   <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      b3_q     <= b3_d;
      pen_q    <= pen_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      open_q   <= open_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      ovr_q    <= ovr_d;
    end
  end
  always_comb begin
    pstate_d = pstate_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    b3_d     = b3_q;
    pen_d    = pen_q;
    valid_d  = valid_q && !touch_ready;
    x_d      = x_q;
    y_d      = y_q;
    open_d   = open_q;
    ferr_d   = byte_ferr;
    perr_d   = 1'b0;
    ovr_d    = 1'b0;
    done     = 1'b0;
    if (byte_valid && byte_data[SYNC_BIT]) begin
      pen_d    = byte_data[PEN_BIT];
      perr_d   = pstate_q != PS_SYNC;
      pstate_d = PS_B1;
    end else if (byte_valid) begin
      case (pstate_q)
        PS_SYNC: pstate_d = PS_SYNC;
        PS_B1: begin
          b1_d     = byte_data[6:0];
          pstate_d = PS_B2;
        end
        PS_B2: begin
          b2_d     = byte_data[4:0];
          pstate_d = PS_B3;
        end
        PS_B3: begin
          b3_d     = byte_data[6:0];
          pstate_d = PS_B4;
        end
        PS_B4: begin
          done     = 1'b1;
          pstate_d = PS_SYNC;
        end
        default: pstate_d = PS_SYNC;
      endcase
    end
    // A held, unaccepted sample wins over the new packet.
    if (done && (!valid_q || touch_ready)) begin
      x_d     = {b2_q, b1_q};
      y_d     = {byte_data[4:0], b3_q};
      open_d  = pen_q;
      valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end
  end
  assign touch_valid = valid_q;
  assign touch_x     = x_q;
  assign touch_y     = y_q;
  assign touch_pen   = open_q;
  assign frame_err   = ferr_q;
  assign pkt_err     = perr_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_touch_uart_rx.sv
// tb_touch_uart_rx: directed self-checking bench for touch_uart_rx at 10 clk/bit
module tb_touch_uart_rx;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rxd = 1'b1;
  logic        touch_ready = 1'b0;
  logic        touch_valid, touch_pen, frame_err, pkt_err, overrun;
  logic [11:0] touch_x, touch_y;
  int checks = 0;
  int failures = 0;
  int fe_n = 0, pe_n = 0, ov_n = 0, beats = 0;
  logic [11:0] cap_x = '0, cap_y = '0;
  logic        cap_pen = 1'b0;
  touch_uart_rx #(.CLK_HZ(1000000), .BAUD(100000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd        (rxd),
    .touch_valid(touch_valid),
    .touch_ready(touch_ready),
    .touch_x    (touch_x),
    .touch_y    (touch_y),
    .touch_pen  (touch_pen),
    .frame_err  (frame_err),
    .pkt_err    (pkt_err),
    .overrun    (overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) fe_n++;
    if (pkt_err) pe_n++;
    if (overrun) ov_n++;
    if (touch_valid && touch_ready) begin
      beats++;
      cap_x   = touch_x;
      cap_y   = touch_y;
      cap_pen = touch_pen;
    end
  end
  task automatic clr();
    fe_n = 0; pe_n = 0; ov_n = 0; beats = 0;
  endtask
  task automatic bit_out(input logic b);
    rxd = b;
    repeat (10) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop_bit = 1'b1,
                           input logic par_ok = 1'b1, input logic chk_lat = 1'b0);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef TOUCH_UART_RX_PARITY_EN
    bit_out(^d ^ !par_ok);
`endif
    rxd = stop_bit;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (chk_lat && i == 7) begin
        checks++;
        if (touch_valid !== 1'b0) begin failures++; $display("FAIL latency_early: valid=%b expected 0", touch_valid); end
      end
      if (chk_lat && i == 8) begin
        checks++;
        if (touch_valid !== 1'b1) begin failures++; $display("FAIL latency_rise: valid=%b expected 1", touch_valid); end
      end
    end
  endtask
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({touch_valid, touch_x, touch_y, touch_pen, frame_err, pkt_err, overrun} !== 28'd0) begin
      failures++; $display("FAIL reset_outputs: got v=%b x=%h y=%h p=%b fe=%b pe=%b ov=%b expected all 0",
        touch_valid, touch_x, touch_y, touch_pen, frame_err, pkt_err, overrun);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    checks++;
    if (touch_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid: got %b expected 0", touch_valid); end
  endtask
  task automatic test_basic();
    clr(); touch_ready = 1'b1;
    send_byte(8'h81); send_byte(8'h34); send_byte(8'h12); send_byte(8'h56);
    send_byte(8'h0A, 1'b1, 1'b1, 1'b1);
    idle(5);
    checks++;
    if (beats !== 1) begin failures++; $display("FAIL basic_beats: got %0d expected 1", beats); end
    checks++;
    if ({cap_pen, cap_x, cap_y} !== {1'b1, 12'h934, 12'h556}) begin
      failures++; $display("FAIL basic_sample: got p=%b x=%h y=%h expected p=1 x=934 y=556", cap_pen, cap_x, cap_y);
    end
    checks++;
    if ({fe_n, pe_n, ov_n} !== {32'd0, 32'd0, 32'd0}) begin
      failures++; $display("FAIL basic_errors: got fe=%0d pe=%0d ov=%0d expected 0", fe_n, pe_n, ov_n);
    end
    checks++;
    if (touch_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_clear: got %b expected 0", touch_valid); end
  endtask
  task automatic test_resync();
    clr(); touch_ready = 1'b1;
    send_byte(8'h80); send_byte(8'h10); send_byte(8'h01);
    send_byte(8'h81); send_byte(8'h00); send_byte(8'h00); send_byte(8'h7F); send_byte(8'h1F);
    idle(5);
    checks++;
    if (pe_n !== 1) begin failures++; $display("FAIL resync_pkt_err: got %0d expected 1", pe_n); end
    checks++;
    if (beats !== 1) begin failures++; $display("FAIL resync_beats: got %0d expected 1", beats); end
    checks++;
    if ({cap_pen, cap_x, cap_y} !== {1'b1, 12'h000, 12'hFFF}) begin
      failures++; $display("FAIL resync_sample: got p=%b x=%h y=%h expected p=1 x=000 y=fff", cap_pen, cap_x, cap_y);
    end
  endtask
  task automatic test_overrun();
    clr(); touch_ready = 1'b0;
    send_byte(8'h81); send_byte(8'h34); send_byte(8'h12); send_byte(8'h56); send_byte(8'h0A);
    send_byte(8'h80); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    idle(5);
    checks++;
    if (ov_n !== 1) begin failures++; $display("FAIL overrun_pulses: got %0d expected 1", ov_n); end
    checks++;
    if ({touch_valid, touch_pen, touch_x, touch_y} !== {1'b1, 1'b1, 12'h934, 12'h556}) begin
      failures++; $display("FAIL overrun_held: got v=%b p=%b x=%h y=%h expected v=1 p=1 x=934 y=556",
        touch_valid, touch_pen, touch_x, touch_y);
    end
    touch_ready = 1'b1;
    @(negedge clk);
    touch_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (touch_valid !== 1'b0) begin failures++; $display("FAIL overrun_drain: valid=%b expected 0", touch_valid); end
    checks++;
    if (beats !== 1) begin failures++; $display("FAIL overrun_beats: got %0d expected 1", beats); end
  endtask
  task automatic test_frame();
    clr(); touch_ready = 1'b1;
    send_byte(8'h81, 1'b0);
    idle(20);
    checks++;
    if (fe_n !== 1) begin failures++; $display("FAIL frame_err_pulse: got %0d expected 1", fe_n); end
    send_byte(8'h80); send_byte(8'h05); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    idle(5);
    checks++;
    if (pe_n !== 0) begin failures++; $display("FAIL frame_ignored: pkt_err count %0d expected 0", pe_n); end
    checks++;
    if ({beats, cap_pen, cap_x, cap_y} !== {32'd1, 1'b0, 12'h005, 12'h003}) begin
      failures++; $display("FAIL frame_next_pkt: got beats=%0d p=%b x=%h y=%h expected 1 p=0 x=005 y=003",
        beats, cap_pen, cap_x, cap_y);
    end
  endtask
  task automatic test_glitch_reset();
    clr(); touch_ready = 1'b1;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    checks++;
    if ({fe_n, pe_n} !== {32'd0, 32'd0}) begin
      failures++; $display("FAIL glitch_errors: got fe=%0d pe=%0d expected 0", fe_n, pe_n);
    end
    send_byte(8'h81); send_byte(8'h11); send_byte(8'h02);
    fork
      send_byte(8'h33);
      begin
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({touch_valid, touch_x, touch_y, touch_pen, frame_err, pkt_err, overrun} !== 28'd0) begin
          failures++; $display("FAIL midpkt_reset: got v=%b x=%h y=%h p=%b fe=%b pe=%b ov=%b expected all 0",
            touch_valid, touch_x, touch_y, touch_pen, frame_err, pkt_err, overrun);
        end
        repeat (70) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    idle(10);
    clr();
    send_byte(8'h81); send_byte(8'h22); send_byte(8'h01); send_byte(8'h44); send_byte(8'h02);
    idle(5);
    checks++;
    if ({beats, pe_n, fe_n} !== {32'd1, 32'd0, 32'd0}) begin
      failures++; $display("FAIL post_reset_counts: got beats=%0d pe=%0d fe=%0d expected 1 0 0", beats, pe_n, fe_n);
    end
    checks++;
    if ({cap_pen, cap_x, cap_y} !== {1'b1, 12'h0A2, 12'h144}) begin
      failures++; $display("FAIL post_reset_sample: got p=%b x=%h y=%h expected p=1 x=0a2 y=144", cap_pen, cap_x, cap_y);
    end
  endtask
`ifdef TOUCH_UART_RX_PARITY_EN
  task automatic test_parity();
    clr(); touch_ready = 1'b1;
    send_byte(8'h81, 1'b1, 1'b0);
    idle(10);
    checks++;
    if (fe_n !== 1) begin failures++; $display("FAIL parity_err: got %0d expected 1", fe_n); end
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h56); send_byte(8'h0A);
    idle(5);
    checks++;
    if (beats !== 0) begin failures++; $display("FAIL parity_no_pkt: got beats=%0d expected 0", beats); end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_resync();
    test_overrun();
    test_frame();
    test_glitch_reset();
`ifdef TOUCH_UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
